// File: rtl/sparse_ram_writer.sv
// rtl/sparse_ram_writer.sv - dense-to-sparse {value, zero-run} RAM encoder with trailing length word
// Optional element statistics outputs: define SPARSE_WRITER_STATS_EN.
module sparse_ram_writer #(
    parameter int RAM_ADDRESS_WIDTH = 14,
    parameter int RAM_VALUE_WIDTH   = 24,
    parameter int INDEX_WIDTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [RAM_VALUE_WIDTH-1:0]   in_value,
    input  logic                         in_last,
    output logic                         ram_we,
    output logic [RAM_ADDRESS_WIDTH-1:0] ram_address,
    output logic [RAM_VALUE_WIDTH-1:0]   ram_value,
    output logic [INDEX_WIDTH-1:0]       ram_index,
    output logic                         busy,
    output logic                         done,
`ifdef SPARSE_WRITER_STATS_EN
    output logic [RAM_ADDRESS_WIDTH+INDEX_WIDTH-1:0] nnz_count,
    output logic [RAM_ADDRESS_WIDTH+INDEX_WIDTH-1:0] zero_count,
`endif
    output logic                         overflow
);

    localparam logic [INDEX_WIDTH-1:0] RUN_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        LEN
    } state_t;

    state_t                     state;
    // One extra bit: wr_ptr[MSB] set means the last address has been written.
    logic [RAM_ADDRESS_WIDTH:0] wr_ptr;
    logic [INDEX_WIDTH-1:0]     run;
    logic                       emit;
    logic                       accept;

    assign accept = (state == STREAM) && in_valid;
    assign emit   = (in_value != '0) || (run == RUN_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_ptr      <= {{RAM_ADDRESS_WIDTH{1'b0}}, 1'b1};
            run         <= '0;
            in_ready    <= 1'b0;
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_value   <= '0;
            ram_index   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
`ifdef SPARSE_WRITER_STATS_EN
            nnz_count   <= '0;
            zero_count  <= '0;
`endif
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state    <= STREAM;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        wr_ptr   <= {{RAM_ADDRESS_WIDTH{1'b0}}, 1'b1};
                        run      <= '0;
                        overflow <= 1'b0;
`ifdef SPARSE_WRITER_STATS_EN
                        nnz_count  <= '0;
                        zero_count <= '0;
`endif
                    end
                end
                STREAM: begin
                    if (accept) begin
                        if (emit) begin
                            run <= '0;
                            if (!wr_ptr[RAM_ADDRESS_WIDTH]) begin
                                ram_we      <= 1'b1;
                                ram_address <= wr_ptr[RAM_ADDRESS_WIDTH-1:0];
                                ram_value   <= in_value;
                                ram_index   <= run;
                                wr_ptr      <= wr_ptr + 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            run <= run + 1'b1;
                        end
`ifdef SPARSE_WRITER_STATS_EN
                        if (in_value != '0) begin
                            if (nnz_count != '1) nnz_count <= nnz_count + 1'b1;
                        end else begin
                            if (zero_count != '1) zero_count <= zero_count + 1'b1;
                        end
`endif
                        if (in_last) begin
                            state    <= LEN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                LEN: begin
                    ram_we      <= 1'b1;
                    ram_address <= '0;
                    ram_value   <= RAM_VALUE_WIDTH'(wr_ptr - 1'b1);
                    ram_index   <= '0;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_ram_writer.sv
// tb/tb_sparse_ram_writer.sv - directed table-driven bench for sparse_ram_writer
module tb_sparse_ram_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_value;
    logic        in_last;
    logic        ram_we;
    logic [3:0]  ram_address;
    logic [23:0] ram_value;
    logic [3:0]  ram_index;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef SPARSE_WRITER_STATS_EN
    logic [7:0]  nnz_count;
    logic [7:0]  zero_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sparse_ram_writer #(
        .RAM_ADDRESS_WIDTH(4),
        .RAM_VALUE_WIDTH(24),
        .INDEX_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_value(in_value),
        .in_last(in_last),
        .ram_we(ram_we),
        .ram_address(ram_address),
        .ram_value(ram_value),
        .ram_index(ram_index),
        .busy(busy),
        .done(done),
`ifdef SPARSE_WRITER_STATS_EN
        .nnz_count(nnz_count),
        .zero_count(zero_count),
`endif
        .overflow(overflow)
    );

    typedef struct {
        bit          gap;
        logic [23:0] v;
        bit          last;
        bit          we;
        logic [3:0]  a;
        logic [23:0] wv;
        logic [3:0]  wi;
        logic [3:0]  len;
        bit          ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit gap, logic [23:0] v, bit last, bit we, logic [3:0] a,
                                logic [23:0] wv, logic [3:0] wi, logic [3:0] len, bit ovf);
        vec_t r;
        r.gap = gap; r.v = v; r.last = last; r.we = we; r.a = a;
        r.wv = wv; r.wi = wi; r.len = len; r.ovf = ovf;
        vecs.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", in_ready, 1);
    endtask

    task automatic run_tile(input int lo, input int hi);
        do_start();
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].gap) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                chk("gap_we", ram_we, 0);
            end
            chk("row_ready", in_ready, 1);
            in_valid = 1'b1;
            in_value = vecs[i].v;
            in_last  = vecs[i].last;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk("row_we", ram_we, vecs[i].we);
            if (vecs[i].we) begin
                chk("row_addr", ram_address, vecs[i].a);
                chk("row_value", ram_value, vecs[i].wv);
                chk("row_index", ram_index, vecs[i].wi);
            end
        end
        chk("len_ready", in_ready, 0);
        chk("len_nodone", done, 0);
        @(posedge clk); #1;
        chk("len_we", ram_we, 1);
        chk("len_addr", ram_address, 0);
        chk("len_value", ram_value, vecs[hi].len);
        chk("len_index", ram_index, 0);
        chk("len_done", done, 1);
        chk("len_busy", busy, 1);
        chk("len_overflow", overflow, vecs[hi].ovf);
        @(posedge clk); #1;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_we", ram_we, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t1_lo, t1_hi, t2_lo, t2_hi, t3_lo, t3_hi, t4_lo, t4_hi, t5_lo, t5_hi, t6_lo, t6_hi;

        // Tile 1: 5,0,0,7,last=9
        t1_lo = vecs.size();
        add(0, 5, 0, 1, 1, 5, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 7, 0, 1, 2, 7, 2, 0, 0);
        add(0, 9, 1, 1, 3, 9, 0, 3, 0);
        t1_hi = vecs.size() - 1;
        // Tile 2: 20 zeros then 4(last); 16th zero saturates the run
        t2_lo = vecs.size();
        for (int k = 1; k <= 20; k++) add(0, 0, 0, k == 16, 1, 0, 15, 0, 0);
        add(0, 4, 1, 1, 2, 4, 4, 2, 0);
        t2_hi = vecs.size() - 1;
        // Tile 3: 6 zeros, last on the 6th
        t3_lo = vecs.size();
        for (int k = 1; k <= 6; k++) add(0, 0, k == 6, 0, 0, 0, 0, 0, 0);
        t3_hi = vecs.size() - 1;
        // Tile 4: 17 nonzeros into 15 entries
        t4_lo = vecs.size();
        for (int k = 1; k <= 17; k++)
            add(0, 24'(k), k == 17, k <= 15, 4'(k), 24'(k), 0, 15, 1);
        t4_hi = vecs.size() - 1;
        // Tile 5: fresh tile after mid-tile reset
        t5_lo = vecs.size();
        add(0, 8, 1, 1, 1, 8, 0, 1, 0);
        t5_hi = vecs.size() - 1;
        // Tile 6: 0,3,0,0,last=0 with valid gaps
        t6_lo = vecs.size();
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 3, 0, 1, 1, 3, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 1, 0);
        t6_hi = vecs.size() - 1;

        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_value = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", ram_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_addr", ram_address, 0);
        reset_n = 1'b1;

        // in_valid while idle is ignored
        in_valid = 1'b1; in_value = 24'h55; in_last = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_we", ram_we, 0);
            chk("idle_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
        end
        in_valid = 1'b0; in_last = 1'b0;

        run_tile(t1_lo, t1_hi);
        run_tile(t2_lo, t2_hi);
        run_tile(t3_lo, t3_hi);
        run_tile(t4_lo, t4_hi);

        // start while busy must not restart the tile
        do_start();
        start = 1'b1; in_valid = 1'b1; in_value = 3; in_last = 1'b0;
        @(posedge clk); #1;
        chk("sb_we", ram_we, 1);
        chk("sb_addr", ram_address, 1);
        in_value = 0; in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        chk("sb_nowe", ram_we, 0);
        @(posedge clk); #1;
        chk("sb_len_we", ram_we, 1);
        chk("sb_len", ram_value, 1);
        chk("sb_done", done, 1);
        @(posedge clk); #1;

        // reset mid-tile
        do_start();
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; in_value = 24'(k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("mr_we_before", ram_we, 1);
        chk("mr_addr_before", ram_address, 3);
        reset_n = 1'b0;
        #1;
        chk("mr_we", ram_we, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ready", in_ready, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("mr_no_len", ram_we, 0);
            chk("mr_no_done", done, 0);
        end
        run_tile(t5_lo, t5_hi);

        run_tile(t6_lo, t6_hi);
`ifdef SPARSE_WRITER_STATS_EN
        chk("stats_nnz", nnz_count, 1);
        chk("stats_zero", zero_count, 4);
        repeat (2) @(posedge clk);
        #1;
        chk("stats_hold_nnz", nnz_count, 1);
        chk("stats_hold_zero", zero_count, 4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
